alu_mul_seq: RTL
================

# alu_mul_seq

Multi-cycle 16-bit multiplier sequencer built around one instance of the team's Hack-style `alu`. It owns the ALU control bits (`zx nx zy ny f no`) and time-multiplexes the single adder over shift-and-add steps to compute `a*b mod 2^16`. It sits beside the CPU datapath as the first sequential consumer of `alu`, so no second adder is needed. It takes a start/done handshake and returns the product with the ALU's `zr`/`ng` flags.

## Interface
- `WIDTH`, default 16: data width. Must be 16, because `alu` is fixed at 16 bits. Any other value is a configuration error.

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  16  multiplicand, two's complement; sampled with `start`
- `b`  in  16  multiplier, two's complement; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse; `product`, `zr` and `ng` are valid from this cycle
- `product`  out  16  low 16 bits of `a*b`; held until the next completion
- `zr`  out  1  `product == 0`, taken from the ALU in FLAGS
- `ng`  out  1  `product[15]`, taken from the ALU in FLAGS

## Operation
- Internal registers: `acc`, `mc` (multiplicand) and `mp` (multiplier, logical right shift), each 16 bits.
- States and the actions taken in each:
  - IDLE: if `start`, then `acc<=0`, `mc<=a`, `mp<=b`, go to STEP. Otherwise stay.
  - STEP: no ALU use. If `mp==0`, go to FLAGS. If `mp[0]==1`, go to ADD. Otherwise go to DBL.
  - ADD: ALU x=`acc`, y=`mc`, controls 000010 (x+y). `acc<=out`. Go to DBL.
  - DBL: ALU x=`mc`, y=`mc`, controls 000010. `mc<=out`, `mp<=mp>>1`. Go to STEP.
  - FLAGS: ALU x=`acc`, controls zx=0 nx=0 zy=1 ny=0 f=1 no=0 (out=x). `product<=out`, `zr<=zr_alu`, `ng<=ng_alu`. Go to DONE.
  - DONE: `done=1`, go to IDLE.
- Arithmetic is modulo 2^16 throughout. The ALU carry is discarded. Two's-complement results are correct for any sign combination. No overflow flag.
- In ADD and DBL, the ALU `zr`/`ng` outputs are ignored.
- When the ALU is unused (IDLE, STEP, DONE), its controls are driven to 101010 (constant 0). This keeps the ALU inputs deterministic.
- Early exit: iteration stops as soon as `mp==0`. The high zero bits of `b` cost nothing.

## Timing
- Reset values: `busy=0`, `done=0`, `product=0`, `zr=0`, `ng=0`. State is IDLE and `acc`, `mc`, `mp` are all 0.
- Definitions:
  - `n` = index of the highest set bit of `b` (as unsigned) + 1, or 0 if `b==0`.
  - `k` = popcount(`b`).
- Latency: if `start` is sampled at edge E0, `done` is high during the cycle after edge E0+(2n+k+2). Minimum is 2 (`b==0`); maximum is 50 (`b==0xFFFF`).
- `busy` rises the cycle after E0. It stays high through DONE and falls when IDLE is re-entered.
- `start` is ignored while `busy=1`. A back-to-back request is accepted in the IDLE cycle after DONE.
- `a` and `b` may change freely after the sampling edge.
- `product`, `zr` and `ng` update only at the FLAGS→DONE edge. They are stable otherwise, including during a following operation.
- `rst` mid-operation: the next edge forces IDLE and all reset values. No `done` is produced for the aborted operation. `rst` has priority over a simultaneous `start`.
- `done` is never high for more than one cycle and is never high while in IDLE.

## Test plan
- Reset: hold `rst` for 2 cycles with `start=1` -> `busy=0`, `done=0`, `product=0`, `zr=0`, `ng=0`. No operation starts.
- Basic and latency: `a=7, b=6` -> `product=42`, `zr=0`, `ng=0`, `done` at 2n+k+2 = 10 cycles after sampling. Then `a=3, b=5` back-to-back -> `product=15`, also 10 cycles.
- Signs and wrap:
  - `a=-3, b=4` -> `product=0xFFF4`, `ng=1`, 9 cycles.
  - `a=2, b=0xFFFF` -> `product=0xFFFE`, `ng=1`, 50 cycles.
  - `a=0x0100, b=0x0100` -> `product=0`, `zr=1`, 21 cycles.
- Zero operands:
  - `a=0, b=9` -> `product=0`, `zr=1`, 12 cycles.
  - `a=1234, b=0` -> `product=0`, `zr=1`, 2 cycles.
- Protocol:
  - Pulse `start` with new operands while `busy` -> the in-flight result is unchanged and no extra `done`.
  - Assert `rst` 3 cycles into `a=5, b=0xFFFF` -> no `done`. The following `a=5, b=5` -> `product=25`.
- Every scenario checks `done` is exactly one cycle wide and `product` holds its value until the next `done`.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16-bit shift-and-add multiplier sequenced over one Hack alu.
// Hosts the alu it drives; the adder is time-shared between ADD and DBL steps.

module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] xa, xb, ya, yb, fo;

    // Hack ALU datapath: zero/negate inputs, add or and, negate output
    always_comb begin
        xa  = zx ? 16'h0000 : x;
        xb  = nx ? ~xa : xa;
        ya  = zy ? 16'h0000 : y;
        yb  = ny ? ~ya : ya;
        fo  = f ? (xb + yb) : (xb & yb);
        out = no ? ~fo : fo;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end
endmodule

module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zr,
    output logic             ng
);
    if (WIDTH != 16) begin : g_width_check
        $error("alu_mul_seq: WIDTH must be 16");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_STEP  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_DBL   = 3'd3;
    localparam logic [2:0] S_FLAGS = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [5:0] C_ZERO = 6'b101010;
    localparam logic [5:0] C_ADD  = 6'b000010;
    localparam logic [5:0] C_PASS = 6'b001010;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;

    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_c;
    logic        alu_zr, alu_ng;

    alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (alu_c[5]),
        .nx  (alu_c[4]),
        .zy  (alu_c[3]),
        .ny  (alu_c[2]),
        .f   (alu_c[1]),
        .no  (alu_c[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // ALU operand/control select; unused states force a constant-0 op
    always_comb begin
        alu_x = '0;
        alu_y = '0;
        alu_c = C_ZERO;
        case (state_q)
            S_ADD: begin
                alu_x = acc_q;
                alu_y = mc_q;
                alu_c = C_ADD;
            end
            S_DBL: begin
                alu_x = mc_q;
                alu_y = mc_q;
                alu_c = C_ADD;
            end
            S_FLAGS: begin
                alu_x = acc_q;
                alu_c = C_PASS;
            end
            default: ;
        endcase
    end

    // Sequencer: iterate over multiplier bits until none remain
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        prod_d  = prod_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mc_d    = a;
                    mp_d    = b;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (mp_q == '0) begin
                    state_d = S_FLAGS;
                end else if (mp_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_DBL;
                end
            end
            S_ADD: begin
                acc_d   = alu_out;
                state_d = S_DBL;
            end
            S_DBL: begin
                mc_d    = alu_out;
                mp_d    = mp_q >> 1;
                state_d = S_STEP;
            end
            S_FLAGS: begin
                prod_d  = alu_out;
                zr_d    = alu_zr;
                ng_d    = alu_ng;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            prod_q  <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            prod_q  <= prod_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;
    assign zr      = zr_q;
    assign ng      = ng_q;
endmodule
